// File: rtl/cmp_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 4-bit comparator among NREQ requesters.
// Optional completed-compare counter (done_cnt) is built when CMP_ARB_CNT_EN is defined.
module cmp_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   ack,
  output logic              res_eq,
  output logic              res_agt,
  output logic              res_bgt,
  output logic              busy,
  output logic [3:0]        cmp_a,
  output logic [3:0]        cmp_b,
  input  logic              cmp_equal,
  input  logic              cmp_agreater,
  input  logic              cmp_bgreater
`ifdef CMP_ARB_CNT_EN
  ,
  output logic [7:0]        done_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]              state;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           cur;
  logic [PW-1:0]           win;
  logic                    found;
  logic [PW:0]             sum;
  logic [PW-1:0]           ptr_nxt;
  logic [NREQ-1:0][3:0]    opa;
  logic [NREQ-1:0][3:0]    opb;

  // Unpack the flat operand buses into per-requester lanes.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign opa[i] = req_a[4*i +: 4];
    assign opb[i] = req_b[4*i +: 4];
  end

  // Scan ptr, ptr+1, ... with wrap; first set request wins.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ))
        sum = sum - (PW+1)'(NREQ);
      if (!found && req[sum[PW-1:0]]) begin
        found = 1'b1;
        win   = sum[PW-1:0];
      end
    end
  end

  assign ptr_nxt = (cur == PW'(NREQ-1)) ? '0 : cur + PW'(1);
  assign busy    = (state != IDLE);

  always_comb begin
    ack = '0;
    if (state == ACK)
      ack[cur] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cur     <= '0;
      res_eq  <= 1'b0;
      res_agt <= 1'b0;
      res_bgt <= 1'b0;
      cmp_a   <= '0;
      cmp_b   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            cmp_a <= opa[win];
            cmp_b <= opb[win];
            cur   <= win;
            state <= CMP;
          end
        end
        CMP: begin
          // Flags forwarded raw, even if the comparator is not one-hot.
          res_eq  <= cmp_equal;
          res_agt <= cmp_agreater;
          res_bgt <= cmp_bgreater;
          state   <= ACK;
        end
        ACK: begin
          ptr   <= ptr_nxt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CMP_ARB_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      done_cnt <= '0;
    else if (state == CMP && done_cnt != 8'hff)
      done_cnt <= done_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin arbiter and sequencer that shares one 4-bit magnitude comparator between NREQ requesters. It latches the winning requester's operand pair onto the comparator inputs and captures the comparator's equal/greater flags one cycle later. It returns the result to that requester with a one-cycle acknowledge pulse. It sits between the requesting blocks and the single comparator instance, which stays purely combinational.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset; one clock, reset is synchronous and active-low.
- req  in  NREQ  request level per requester; held until the matching ack.
- req_a  in  4*NREQ  A operands; requester i uses bits [4i+3:4i].
- req_b  in  4*NREQ  B operands; same packing as req_a.
- ack  out  NREQ  one-hot, one-cycle pulse; results are valid while it is high.
- res_eq  out  1  A == B for the acknowledged request.
- res_agt  out  1  A > B for the acknowledged request.
- res_bgt  out  1  B > A for the acknowledged request.
- busy  out  1  high in CMP and ACK states.
- cmp_a  out  4  drives the comparator A input (a=bit0 .. d=bit3).
- cmp_b  out  4  drives the comparator B input (f=bit0 .. j=bit3).
- cmp_equal, cmp_agreater, cmp_bgreater  in  1 each  comparator outputs.
- done_cnt  out  8  completed-compare count; present only with CMP_ARB_CNT_EN.

## Operation
- FSM states: IDLE, CMP, ACK. Reset state: IDLE.
- **IDLE.**
  - If req is zero, stay in IDLE.
  - Otherwise select the winner as the first index i in the order ptr, ptr+1, …, NREQ-1, 0, … with req[i]=1.
  - Latch the winner's req_a slice into cmp_a and its req_b slice into cmp_b, store the index in cur, set busy=1, and go to CMP.
- **CMP.**
  - cmp_a and cmp_b are stable for the whole cycle.
  - At the clock edge, register cmp_equal, cmp_agreater and cmp_bgreater into res_eq, res_agt and res_bgt.
  - Set ack[cur]=1 and go to ACK.
- **ACK.**
  - ack[cur] is high for exactly this cycle.
  - At the edge: clear ack, set ptr to cur+1 (wrapping NREQ-1 to 0), clear busy, and go to IDLE.
- **Results.**
  - res_* hold their value until the next capture.
  - Flags pass through unchecked; a non-one-hot comparator output is forwarded as-is.
  - cmp_a and cmp_b hold their last operands while in IDLE.
- **Requester rule.**
  - A requester drops req on the edge that samples its ack high.
  - req is sampled only in IDLE.
  - Deasserting req during CMP or ACK does not cancel the compare; ack is still issued.
- Operands are sampled only at the IDLE→CMP edge; they may change afterwards.

## Timing
- Reset (rst_n low at a rising edge):
  - state=IDLE, ptr=0, cur=0.
  - ack=0, busy=0.
  - res_eq=res_agt=res_bgt=0.
  - cmp_a=cmp_b=0, done_cnt=0.
- Reset during CMP or ACK aborts the compare: no ack is issued and ptr returns to 0.
- Latency: req sampled at edge E0, then ack high from E1 to E2, then IDLE again after E2. The earliest next grant is at E3.
- Throughput: one compare per 3 cycles under continuous requests.
- Fairness: a continuously requesting requester waits at most NREQ-1 other grants.
- Wrap-around: with ptr=NREQ-1 and only req[0] set, requester 0 wins.

## Configuration
- CMP_ARB_CNT_EN defined:
  - done_cnt port exists.
  - It increments on each ack pulse (at the CMP→ACK edge) and saturates at 255.
  - It resets to 0.
- CMP_ARB_CNT_EN undefined:
  - done_cnt port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- **Reset.** Hold rst_n=0 for 2 cycles with req=4'b1111.
  - During reset: ack=0, busy=0, cmp_a=cmp_b=0.
  - After release: first ack=4'b0001.
- **Single requester.** req=4'b0100 with A2=1001, B2=1000.
  - cmp_a=1001 and cmp_b=1000 in CMP.
  - ack=4'b0100 one cycle later, with res_agt=1, res_eq=0, res_bgt=0.
- **Flag coverage on requester 1.**
  - 1101 vs 1101 → res_eq=1.
  - 1011 vs 1100 → res_bgt=1.
  - 1111 vs 1101 → res_agt=1.
- **Round-robin.** req=4'b1111 held continuously, each requester releasing for one cycle after its ack.
  - ack sequence 0001, 0010, 0100, 1000, 0001.
  - Acks spaced exactly 3 cycles apart.
- **Abort.** Assert rst_n=0 in the CMP state of a grant to requester 2.
  - No ack pulse is issued.
  - After release with req=4'b0110, requester 1 is granted first.
- **Counter (CMP_ARB_CNT_EN).** Run 260 single-requester compares → done_cnt reads 255 and stays there.
